// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues sequential fetches on the inst SRAM bus,
// buffers returned instructions and redirects on exception, ertn or branch.
module if_prefetch #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_flush,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    input  logic        id_allowin,
    output logic        if_id_valid,
    output logic [64:0] if_id_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int              PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int              BW      = $clog2(IBUF_DEPTH);
    localparam logic [3:0]      MAX_C   = 4'(MAX_OUTSTANDING);
    localparam logic [3:0]      DEPTH_C = 4'(IBUF_DEPTH);
    localparam logic [PW-1:0]   PC_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc;
    logic [3:0]    out_cnt;
    logic [3:0]    buf_cnt;
    logic [3:0]    discard_cnt;
    logic          halted;
    logic [PW-1:0] pcf_wr;
    logic [PW-1:0] pcf_rd;
    logic [31:0]   pcf_mem [MAX_OUTSTANDING];
    logic [BW-1:0] buf_head;
    logic [BW-1:0] buf_tail;
    logic [64:0]   buf_mem [IBUF_DEPTH];

    logic          redirect;
    logic [31:0]   redirect_target;
    logic [3:0]    occupancy;
    logic          aligned;
    logic          issue;
    logic          adef_push;
    logic          data_write;
    logic          buf_push;
    logic          buf_pop;
    logic [64:0]   buf_entry;
    logic [3:0]    out_cnt_nxt;

    function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
        return (p == PC_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        redirect_target = br_target;
        if (ex_flush)
            redirect_target = ex_entry;
        else if (ertn_flush)
            redirect_target = ertn_entry;
    end

    assign redirect  = ex_flush | ertn_flush | br_taken;
    // Outstanding fetches reserve buffer slots so returning data can never overflow.
    assign occupancy = out_cnt + buf_cnt;
    assign aligned   = (fetch_pc[1:0] == 2'b00);

    assign inst_sram_req   = resetn & ~redirect & ~br_stall & ~halted & aligned
                           & (out_cnt < MAX_C) & (occupancy < DEPTH_C);
    assign inst_sram_addr  = redirect ? redirect_target : fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign issue       = inst_sram_req & inst_sram_addr_ok;
    // A misaligned pc turns into one adef entry once everything in flight has drained.
    assign adef_push   = ~redirect & ~halted & ~aligned & (out_cnt == 4'd0) & (buf_cnt < DEPTH_C);
    assign data_write  = inst_sram_data_ok & ~redirect & (discard_cnt == 4'd0);
    assign buf_push    = data_write | adef_push;
    assign buf_entry   = adef_push ? {1'b1, fetch_pc, 32'h0}
                                   : {1'b0, pcf_mem[pcf_rd], inst_sram_rdata};
    assign out_cnt_nxt = out_cnt + 4'(issue) - 4'(inst_sram_data_ok);

    assign if_id_valid = resetn & (buf_cnt != 4'd0) & ~redirect;
    assign if_id_bus   = resetn ? buf_mem[buf_head] : 65'h0;
    assign buf_pop     = if_id_valid & id_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            out_cnt     <= 4'd0;
            buf_cnt     <= 4'd0;
            discard_cnt <= 4'd0;
            halted      <= 1'b0;
            pcf_wr      <= '0;
            pcf_rd      <= '0;
            buf_head    <= '0;
            buf_tail    <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (issue)
                pcf_wr <= pcf_next(pcf_wr);
            if (inst_sram_data_ok)
                pcf_rd <= pcf_next(pcf_rd);
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc    <= redirect_target;
                buf_cnt     <= 4'd0;
                buf_head    <= '0;
                buf_tail    <= '0;
                discard_cnt <= out_cnt_nxt;
                halted      <= 1'b0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (inst_sram_data_ok && discard_cnt != 4'd0)
                    discard_cnt <= discard_cnt - 4'd1;
                if (adef_push)
                    halted <= 1'b1;
                if (buf_push)
                    buf_tail <= buf_tail + BW'(1);
                if (buf_pop)
                    buf_head <= buf_head + BW'(1);
                buf_cnt <= buf_cnt + 4'(buf_push) - 4'(buf_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            pcf_mem[pcf_wr] <= fetch_pc;
        if (buf_push)
            buf_mem[buf_tail] <= buf_entry;
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a latency-programmable memory responder feeds
// the fetch bus and a scoreboard checks every instruction handed to decode.
module tb_if_prefetch;

    logic        clk;
    logic        resetn;
    logic        ex_flush;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] ertn_entry;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_stall;
    logic        id_allowin;
    logic        if_id_valid;
    logic [64:0] if_id_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_prefetch dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_flush          (ex_flush),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_entry        (ertn_entry),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .br_stall          (br_stall),
        .id_allowin        (id_allowin),
        .if_id_valid       (if_id_valid),
        .if_id_bus         (if_id_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int extra  = 0;
    logic [64:0] exp_q[$];

    task automatic chk_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hdead0000;
    endfunction

    function automatic logic [64:0] ent(input logic [31:0] pc);
        return {1'b0, pc, mem_data(pc)};
    endfunction

    // Memory responder: data returns lat windows after the address is accepted.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int win = 0;
    int lat = 1;

    always @(posedge clk) begin
        #1;
        win++;
        inst_sram_data_ok = resetn && (mq.size() > 0) && (mq[0].due <= win);
        inst_sram_rdata   = inst_sram_data_ok ? mem_data(mq[0].addr) : 32'h0;
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (inst_sram_req && inst_sram_addr_ok)
                mq.push_back('{addr: inst_sram_addr, due: win + lat});
            if (inst_sram_data_ok)
                void'(mq.pop_front());
        end
    end

    always @(negedge resetn) begin
        mq.delete();
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
    end

    // Scoreboard on the decode side
    always @(negedge clk) begin
        if (resetn && if_id_valid && id_allowin) begin
            if (exp_q.size() > 0) begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk_eq("deliver", if_id_bus, e);
            end else begin
                extra++;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        ex_flush          = 1'b0;
        ex_entry          = 32'h0;
        ertn_flush        = 1'b0;
        ertn_entry        = 32'h0;
        br_taken          = 1'b0;
        br_target         = 32'h0;
        br_stall          = 1'b0;
        id_allowin        = 1'b0;
        inst_sram_addr_ok = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_ctl();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic end_test(input string tag);
        chk_eq({tag, "_left"}, 65'(exp_q.size()), 65'd0);
        chk_eq({tag, "_extra"}, 65'(extra), 65'd0);
        exp_q.delete();
        extra = 0;
    endtask

    initial begin
        resetn            = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        clear_ctl();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req", 65'(inst_sram_req), 65'd0);
        chk_eq("rst_valid", 65'(if_id_valid), 65'd0);
        chk_eq("rst_bus", if_id_bus, 65'h0);
        chk_eq("tie_wr", 65'(inst_sram_wr), 65'd0);
        chk_eq("tie_size", 65'(inst_sram_size), 65'd2);
        chk_eq("tie_wstrb", 65'(inst_sram_wstrb), 65'd0);
        chk_eq("tie_wdata", 65'(inst_sram_wdata), 65'd0);

        // Streaming at full rate
        do_reset();
        lat = 1; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'h1c000000 + 32'(4 * i)));
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            settle();
            if (i < 4) begin
                chk_eq("B_req", 65'(inst_sram_req), 65'd1);
                chk_eq("B_addr", 65'(inst_sram_addr), 65'(32'h1c000000 + 32'(4 * i)));
            end
            if (i == 1) chk_eq("B_valid_w1", 65'(if_id_valid), 65'd0);
            if (i == 2) chk_eq("B_valid_w2", 65'(if_id_valid), 65'd1);
        end
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (5) tick();
        end_test("B");

        // Decode stalled: buffer fills to four entries, then drains in order
        do_reset();
        lat = 1; id_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(ent(32'h1c000000 + 32'(4 * i)));
        repeat (8) tick();
        settle();
        chk_eq("C_full_req", 65'(inst_sram_req), 65'd0);
        chk_eq("C_full_valid", 65'(if_id_valid), 65'd1);
        chk_eq("C_head", if_id_bus, ent(32'h1c000000));
        tick(); id_allowin = 1'b1;
        settle();
        chk_eq("C_pop_req", 65'(inst_sram_req), 65'd0);
        tick();
        settle();
        chk_eq("C_resume_req", 65'(inst_sram_req), 65'd1);
        chk_eq("C_resume_addr", 65'(inst_sram_addr), 65'h1c000010);
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (6) tick();
        end_test("C");

        // Branch while two fetches are in flight
        do_reset();
        lat = 3; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1;
        exp_q.push_back(ent(32'h1c000100));
        exp_q.push_back(ent(32'h1c000104));
        settle();
        tick(); settle();
        tick(); inst_sram_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1c000100;
        settle();
        chk_eq("D_redir_req", 65'(inst_sram_req), 65'd0);
        chk_eq("D_redir_addr", 65'(inst_sram_addr), 65'h1c000100);
        chk_eq("D_redir_valid", 65'(if_id_valid), 65'd0);
        tick(); br_taken = 1'b0; inst_sram_addr_ok = 1'b1;
        settle();
        chk_eq("D_full_req", 65'(inst_sram_req), 65'd0);
        tick(); settle();
        chk_eq("D_tgt_req", 65'(inst_sram_req), 65'd1);
        chk_eq("D_tgt_addr", 65'(inst_sram_addr), 65'h1c000100);
        tick(); settle();
        chk_eq("D_tgt4_addr", 65'(inst_sram_addr), 65'h1c000104);
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (6) tick();
        end_test("D");

        // Exception and branch together: exception target wins
        do_reset();
        lat = 1; id_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
        exp_q.push_back(ent(32'h1c008000));
        settle();
        tick(); settle();
        tick();
        ex_flush = 1'b1; ex_entry = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000100;
        settle();
        chk_eq("E_redir_req", 65'(inst_sram_req), 65'd0);
        chk_eq("E_redir_addr", 65'(inst_sram_addr), 65'h1c008000);
        chk_eq("E_redir_valid", 65'(if_id_valid), 65'd0);
        tick(); ex_flush = 1'b0; br_taken = 1'b0; id_allowin = 1'b1;
        settle();
        chk_eq("E_empty", 65'(if_id_valid), 65'd0);
        chk_eq("E_req", 65'(inst_sram_req), 65'd1);
        chk_eq("E_addr", 65'(inst_sram_addr), 65'h1c008000);
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (5) tick();
        end_test("E");

        // Misaligned branch target produces one adef entry and halts
        do_reset();
        lat = 2; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1;
        exp_q.push_back({1'b1, 32'h1c000102, 32'h0});
        settle();
        tick(); inst_sram_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1c000102;
        settle();
        chk_eq("F_redir_req", 65'(inst_sram_req), 65'd0);
        tick(); br_taken = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            settle();
            chk_eq("F_no_req", 65'(inst_sram_req), 65'd0);
        end
        tick(); ex_flush = 1'b1; ex_entry = 32'h1c000200;
        settle();
        chk_eq("F_flush_req", 65'(inst_sram_req), 65'd0);
        tick(); ex_flush = 1'b0;
        settle();
        chk_eq("F_resume_req", 65'(inst_sram_req), 65'd1);
        chk_eq("F_resume_addr", 65'(inst_sram_addr), 65'h1c000200);
        end_test("F");

        // br_stall blocks requests only
        do_reset();
        lat = 1; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1;
        exp_q.push_back(ent(32'h1c000000));
        exp_q.push_back(ent(32'h1c000004));
        settle();
        tick(); br_stall = 1'b1;
        settle();
        chk_eq("H_stall_req", 65'(inst_sram_req), 65'd0);
        tick(); settle();
        chk_eq("H_stall_req2", 65'(inst_sram_req), 65'd0);
        chk_eq("H_valid", 65'(if_id_valid), 65'd1);
        chk_eq("H_bus", if_id_bus, ent(32'h1c000000));
        tick(); br_stall = 1'b0;
        settle();
        chk_eq("H_req", 65'(inst_sram_req), 65'd1);
        chk_eq("H_addr", 65'(inst_sram_addr), 65'h1c000004);
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (4) tick();
        end_test("H");

        // Reset in the middle of a stream with two fetches outstanding
        do_reset();
        lat = 3; id_allowin = 1'b1; inst_sram_addr_ok = 1'b1;
        exp_q.push_back(ent(32'h1c000000));
        settle();
        tick(); settle();
        tick();
        resetn = 1'b0;
        #1;
        chk_eq("G_rst_req", 65'(inst_sram_req), 65'd0);
        chk_eq("G_rst_valid", 65'(if_id_valid), 65'd0);
        chk_eq("G_rst_bus", if_id_bus, 65'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1; lat = 1;
        settle();
        chk_eq("G_req", 65'(inst_sram_req), 65'd1);
        chk_eq("G_addr", 65'(inst_sram_addr), 65'h1c000000);
        tick(); inst_sram_addr_ok = 1'b0;
        repeat (5) tick();
        end_test("G");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        n_fail++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
